result_stream_tx: RTL and testbench
===================================

Name: result_stream_tx

Overview:
- Output end of the IMG2COL_GEMM result path.
- Collects GEMM results from the compute array in production order into a local buffer sized from the convolution configuration.
- Once all results are in, streams them out one per clock on dout, framed by w_done, in the order the result-checking bench compares against the software reference.
- Sits between the GEMM array and the TOP output ports (dout, w_done).

Parameters:
RESULT_SIZE, 32, result word width (matches `RESULT_SIZE)
CFG_W, 8, width of each configuration field
DEPTH, 4096, result buffer entries
ADDR_W, 12, log2(DEPTH)

Ports:
clk  in  1  clock
rstn  in  1  async active-low reset
start  in  1  level; high starts a job from IDLE
tensor_size  in  CFG_W  input feature map edge T
kernel_size  in  CFG_W  kernel edge K
stride  in  CFG_W  stride S
kernel_nums  in  CFG_W  number of kernels N
res_wr_en  in  1  result write strobe from GEMM array
res_wr_data  in  RESULT_SIZE  result word
cfg_ready  out  1  high while writes are accepted (COLLECT)
cfg_err  out  1  sticky illegal-configuration flag
ovf_err  out  1  sticky write-overflow flag
w_done  out  1  read-out frame, high exactly TOTAL cycles
dout_valid  out  1  w_done delayed by one cycle
dout  out  RESULT_SIZE  streamed result word

Behaviour:
- Reset (rstn=0, async): state=IDLE. All outputs 0. Pointers and counters 0. Buffer contents are don't-care.
- Reset asserted mid-job aborts immediately. Nothing else aborts a job; start falling mid-job is ignored.

States:
- IDLE: if start=1, latch T, K, S, N.
  - If S==0, K>T, or N==0: go to ERR.
  - Otherwise go to CALC with rem=T-K, q=0.
- CALC: iterative divide, one step per cycle.
  - If rem>=S: rem-=S, q++.
  - Else: OD=q+1, then compute TOTAL=OD*OD*N (24-bit, no truncation).
  - If TOTAL>DEPTH go to ERR, else go to COLLECT.
  - CALC latency is at most 257 cycles.
- COLLECT: cfg_ready=1.
  - Each res_wr_en writes res_wr_data to mem[wr_ptr], then wr_ptr++.
  - On the cycle the TOTAL-th write lands, go to DRAIN next cycle. cfg_ready falls with that transition.
- DRAIN:
  - w_done=1 from the first DRAIN cycle for exactly TOTAL cycles.
  - Synchronous read of mem[rd_ptr], rd_ptr++ each cycle.
  - Read latency is 1: dout_valid=1 and dout=mem[i] on the i-th cycle after w_done rose (i=0..TOTAL-1).
  - After the last read issues, go to DONE.
- DONE: w_done=0. dout_valid=1 for one final cycle, then 0. dout holds the last word. Return to IDLE when start==0.
- ERR: cfg_err=1 (sticky until reset). w_done is never asserted. Return to IDLE when start==0; cfg_err stays set.

Write handling outside COLLECT:
- res_wr_en outside COLLECT (IDLE, CALC, DRAIN, DONE, ERR) is dropped. Data is not written.
- A write outside COLLECT sets ovf_err only in DRAIN or DONE (an extra result). In IDLE/CALC it is dropped silently, since upstream must wait for cfg_ready.
- res_wr_en is never lost within COLLECT; the buffer has no back-pressure.

Output timing:
- dout changes only on dout_valid cycles. Otherwise it holds.
- Sampling rule for consumers: register w_done once; when the registered copy is 1, dout is the next expected result.

Test Plan:
- T=5,K=3,S=1,N=2: OD=3, TOTAL=18. Write 1..18 on consecutive cycles. w_done high 18 cycles; dout_valid cycles show 1..18 in order. cfg_err=ovf_err=0.
- T=7,K=3,S=2,N=1, writes with gaps (every 3rd cycle), values -4..4 signed. Divider gives OD=3, TOTAL=9. Stream starts only after the 9th write; dout = -4..4 with no gaps.
- Illegal configs, one per run: K=5>T=3; S=0; N=0; T=255,K=1,S=1,N=1 (TOTAL=65025>DEPTH). Each -> cfg_err=1, w_done stays 0, cfg_ready stays 0.
- T=4,K=2,S=1,N=1 (TOTAL=9). Write 9 words, then 2 extra strobes during DRAIN -> ovf_err=1, stream is still exactly the 9 original words.
- Reset mid-DRAIN after 4 words (rstn low for 2 cycles) -> all outputs 0 immediately. Re-run with start and a new config -> full correct stream from word 0.
- Back-to-back jobs: drop start after DONE, then raise it with a new config. The second stream contains only second-job data. cfg_err and ovf_err stay 0.

Source files
------------

// File: rtl/result_stream_tx.sv
// result_stream_tx: buffers one convolution job's GEMM results, then streams them
// out one per clock, framed by w_done, with dout_valid trailing by one cycle.
module result_stream_tx #(
  parameter int RESULT_SIZE = 32,
  parameter int CFG_W = 8,
  parameter int DEPTH = 4096,
  parameter int ADDR_W = 12
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [CFG_W-1:0]       tensor_size,
  input  logic [CFG_W-1:0]       kernel_size,
  input  logic [CFG_W-1:0]       stride,
  input  logic [CFG_W-1:0]       kernel_nums,
  input  logic                   res_wr_en,
  input  logic [RESULT_SIZE-1:0] res_wr_data,
  output logic                   cfg_ready,
  output logic                   cfg_err,
  output logic                   ovf_err,
  output logic                   w_done,
  output logic                   dout_valid,
  output logic [RESULT_SIZE-1:0] dout
);
  typedef enum logic [2:0] {IDLE, CALC, COLLECT, DRAIN, DONE, ERR} state_t;
  state_t state;
  logic [CFG_W-1:0] s_r, n_r, rem, q;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, last;
  logic [RESULT_SIZE-1:0] mem [DEPTH];
  logic [23:0] od, total;
  assign od = 24'(q) + 24'd1;
  assign total = od * od * 24'(n_r);
  always_ff @(posedge clk)
    if (state == COLLECT && res_wr_en) mem[wr_ptr] <= res_wr_data;
  // w_done is high exactly while in DRAIN, so it doubles as the read enable
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      s_r <= '0;
      n_r <= '0;
      rem <= '0;
      q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      last <= '0;
      cfg_ready <= 1'b0;
      cfg_err <= 1'b0;
      ovf_err <= 1'b0;
      w_done <= 1'b0;
      dout_valid <= 1'b0;
      dout <= '0;
    end else begin
      dout_valid <= w_done;
      if (w_done) dout <= mem[rd_ptr];
      if (res_wr_en && (state == DRAIN || state == DONE)) ovf_err <= 1'b1;
      case (state)
        IDLE: if (start) begin
          s_r <= stride;
          n_r <= kernel_nums;
          rem <= tensor_size - kernel_size;
          q <= '0;
          wr_ptr <= '0;
          rd_ptr <= '0;
          if (stride == '0 || kernel_size > tensor_size || kernel_nums == '0) begin
            state <= ERR;
            cfg_err <= 1'b1;
          end else state <= CALC;
        end
        CALC: if (rem >= s_r) begin
          rem <= rem - s_r;
          q <= q + CFG_W'(1);
        end else if (total > 24'(DEPTH)) begin
          state <= ERR;
          cfg_err <= 1'b1;
        end else begin
          last <= ADDR_W'(total - 24'd1);
          state <= COLLECT;
          cfg_ready <= 1'b1;
        end
        COLLECT: if (res_wr_en) begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
          if (wr_ptr == last) begin
            state <= DRAIN;
            cfg_ready <= 1'b0;
            w_done <= 1'b1;
          end
        end
        DRAIN: begin
          rd_ptr <= rd_ptr + ADDR_W'(1);
          if (rd_ptr == last) begin
            state <= DONE;
            w_done <= 1'b0;
          end
        end
        DONE, ERR: if (!start) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_result_stream_tx.sv
// tb_result_stream_tx: directed jobs; written words are queued and matched against the stream.
module tb_result_stream_tx;
  logic clk = 0, rstn = 1, start = 0, res_wr_en = 0;
  logic [7:0] tensor_size = 0, kernel_size = 0, stride = 0, kernel_nums = 0;
  logic [31:0] res_wr_data = 0;
  logic cfg_ready, cfg_err, ovf_err, w_done, dout_valid;
  logic [31:0] dout;
  logic [31:0] sb[$];
  logic prev_wd = 0;
  int vectors = 0, miscompares = 0, nout = 0, wd_cnt = 0;

  always #5 clk = ~clk;

  result_stream_tx dut (
    .clk(clk), .rstn(rstn), .start(start),
    .tensor_size(tensor_size), .kernel_size(kernel_size), .stride(stride), .kernel_nums(kernel_nums),
    .res_wr_en(res_wr_en), .res_wr_data(res_wr_data),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .ovf_err(ovf_err),
    .w_done(w_done), .dout_valid(dout_valid), .dout(dout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (w_done) wd_cnt++;
    if (dout_valid) begin
      chk("valid_after_wdone", 32'(prev_wd), 32'd1);
      if (sb.size() == 0) chk("stream_extra_word", 32'(sb.size()), 32'd1);
      else begin
        chk("stream_word", dout, sb.pop_front());
        nout++;
      end
    end
    prev_wd = w_done;
  end

  task automatic do_reset();
    @(negedge clk);
    rstn = 0;
    start = 0;
    res_wr_en = 0;
    #1;
    chk("reset_flags", 32'({cfg_ready, cfg_err, ovf_err, w_done, dout_valid}), 32'd0);
    chk("reset_dout", dout, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1;
    sb.delete();
    nout = 0;
    wd_cnt = 0;
  endtask

  task automatic start_job(input logic [7:0] t, input logic [7:0] k, input logic [7:0] s, input logic [7:0] n);
    @(negedge clk);
    start = 0;
    @(negedge clk);
    tensor_size = t;
    kernel_size = k;
    stride = s;
    kernel_nums = n;
    start = 1;
    wd_cnt = 0;
    nout = 0;
  endtask

  task automatic wait_ready();
    int i = 0;
    while (!cfg_ready && i < 400) begin
      @(negedge clk);
      i++;
    end
    chk("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
  endtask

  task automatic write_words(input int first, input int cnt, input int gap);
    for (int i = 0; i < cnt; i++) begin
      res_wr_en = 1;
      res_wr_data = 32'(first + i);
      sb.push_back(32'(first + i));
      @(negedge clk);
      res_wr_en = 0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_stream(input int total);
    int i = 0;
    while ((sb.size() != 0 || dout_valid) && i < 5000) begin
      @(negedge clk);
      i++;
    end
    chk("stream_timeout", 32'(i < 5000), 32'd1);
    chk("stream_len", 32'(nout), 32'(total));
    chk("w_done_cycles", 32'(wd_cnt), 32'(total));
    chk("w_done_low_after", 32'(w_done), 32'd0);
  endtask

  task automatic bad_job(input logic [7:0] t, input logic [7:0] k, input logic [7:0] s, input logic [7:0] n);
    logic rdy = 0;
    do_reset();
    start_job(t, k, s, n);
    repeat (300) begin
      @(negedge clk);
      rdy |= cfg_ready;
    end
    chk("bad_cfg_err", 32'(cfg_err), 32'd1);
    chk("bad_cfg_ready", 32'(rdy), 32'd0);
    chk("bad_w_done", 32'(wd_cnt), 32'd0);
  endtask

  initial begin
    int i;
    do_reset();
    // T5 K3 S1 N2 -> OD 3, 18 words back to back
    start_job(5, 3, 1, 2);
    wait_ready();
    write_words(1, 18, 0);
    wait_stream(18);
    chk("done_dout_hold", dout, 32'd18);
    chk("j1_cfg_err", 32'(cfg_err), 32'd0);
    chk("j1_ovf_err", 32'(ovf_err), 32'd0);
    // back-to-back: T7 K3 S2 N1 -> OD 3, signed words with gaps
    start_job(7, 3, 2, 1);
    wait_ready();
    write_words(-4, 8, 2);
    chk("early_frame", 32'(wd_cnt), 32'd0);
    write_words(4, 1, 0);
    wait_stream(9);
    chk("done_dout_neg", dout, 32'd4);
    chk("j2_cfg_err", 32'(cfg_err), 32'd0);
    chk("j2_ovf_err", 32'(ovf_err), 32'd0);
    // extra strobes during DRAIN must flag overflow but not alter the stream
    start_job(4, 2, 1, 1);
    wait_ready();
    write_words(100, 9, 0);
    res_wr_en = 1;
    res_wr_data = 32'd99;
    repeat (2) @(negedge clk);
    res_wr_en = 0;
    wait_stream(9);
    chk("ovf_set", 32'(ovf_err), 32'd1);
    chk("ovf_cfg_err", 32'(cfg_err), 32'd0);
    // reset mid-DRAIN, then a fresh job streams from word 0
    start_job(5, 3, 1, 2);
    wait_ready();
    write_words(200, 18, 0);
    i = 0;
    while (nout < 4 && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("mid_drain_reached", 32'(nout >= 4), 32'd1);
    do_reset();
    start_job(4, 2, 1, 1);
    wait_ready();
    write_words(300, 9, 0);
    wait_stream(9);
    chk("rerun_cfg_err", 32'(cfg_err), 32'd0);
    chk("rerun_ovf_err", 32'(ovf_err), 32'd0);
    // illegal configurations
    bad_job(3, 5, 1, 1);
    bad_job(5, 3, 0, 1);
    bad_job(5, 3, 1, 0);
    bad_job(255, 1, 1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
